// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction fetch stage. Issues in-order word requests on the
//                instruction bus, buffers up to two returned instructions and
//                presents them to decode. Supports stall (i_stop) and
//                redirect (i_flush); responses still in flight at a redirect
//                are counted and discarded when they arrive.
//                Optional build macro IF_MISALIGN_CHECK_EN adds o_misalign and
//                blocks fetch after a redirect to a non word-aligned target.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stop,
    input  logic        i_flush,
    input  logic [31:0] i_jump_addr,
    output logic        o_ibus_req,
    output logic [31:0] o_ibus_addr,
    input  logic        i_ibus_gnt,
    input  logic        i_ibus_rvalid,
    input  logic [31:0] i_ibus_rdata,
`ifdef IF_MISALIGN_CHECK_EN
    output logic        o_misalign,
`endif
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc
);

    // Fetch PC and request bookkeeping
    logic [31:0] pc_q,      pc_d;
    logic [1:0]  outst_q,   outst_d;   // granted requests awaiting data
    logic [2:0]  drop_q,    drop_d;    // stale responses still to discard
    logic [1:0]  occ_q,     occ_d;     // buffer occupancy

    // Two-entry in-order buffer, entry 0 is the head
    logic [31:0] b0_inst_q, b0_inst_d;
    logic [31:0] b0_pc_q,   b0_pc_d;
    logic [31:0] b1_inst_q, b1_inst_d;
    logic [31:0] b1_pc_q,   b1_pc_d;

    logic        w_req;
    logic        w_grant;
    logic        w_rsp_keep;
    logic        w_rsp_drop;
    logic        w_pop;
    logic [31:0] w_rsp_pc;
    logic [31:0] w_jump_pc;
    logic [2:0]  w_drop_sum;
    logic        w_fetch_block;

`ifdef IF_MISALIGN_CHECK_EN
    logic        misalign_q, misalign_d;

    assign w_jump_pc     = i_jump_addr;
    assign w_fetch_block = misalign_q;
    assign o_misalign    = misalign_q;
`else
    // Redirect targets are always forced onto a word boundary.
    logic        w_unused_jump_lo;

    assign w_jump_pc        = {i_jump_addr[31:2], 2'b00};
    assign w_unused_jump_lo = ^i_jump_addr[1:0];
    assign w_fetch_block    = 1'b0;
`endif

    assign w_req      = ({1'b0, occ_q} + {1'b0, outst_q} < 3'd2) && !i_flush && !w_fetch_block;
    assign w_grant    = w_req && i_ibus_gnt;
    assign w_rsp_keep = i_ibus_rvalid && (drop_q == 3'd0);
    assign w_rsp_drop = i_ibus_rvalid && (drop_q != 3'd0);
    assign w_pop      = (occ_q != 2'd0) && !i_stop && !i_flush;

    // Outstanding requests are always consecutive words ending just below pc,
    // so the oldest one sits outst_q words back.
    assign w_rsp_pc   = pc_q - {28'd0, outst_q, 2'b00};

    // Everything still in flight at a redirect becomes stale.
    assign w_drop_sum = drop_q + {1'b0, outst_q};

    assign o_ibus_req   = w_req;
    assign o_ibus_addr  = pc_q;
    assign o_inst_valid = (occ_q != 2'd0);
    assign o_inst       = (occ_q != 2'd0) ? b0_inst_q : NOP_INST;
    assign o_inst_pc    = (occ_q != 2'd0) ? b0_pc_q   : pc_q;

    // Next-state logic: redirect, request issue, response capture and pop
    always_comb begin
        pc_d      = pc_q;
        outst_d   = outst_q;
        drop_d    = drop_q;
        occ_d     = occ_q;
        b0_inst_d = b0_inst_q;
        b0_pc_d   = b0_pc_q;
        b1_inst_d = b1_inst_q;
        b1_pc_d   = b1_pc_q;
`ifdef IF_MISALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        if (i_flush) begin
            occ_d   = 2'd0;
            outst_d = 2'd0;
            pc_d    = w_jump_pc;
            // A response arriving in the flush cycle is itself stale.
            drop_d  = (i_ibus_rvalid && (w_drop_sum != 3'd0)) ? (w_drop_sum - 3'd1) : w_drop_sum;
`ifdef IF_MISALIGN_CHECK_EN
            misalign_d = |i_jump_addr[1:0];
`endif
        end else begin
            if (w_grant) begin
                pc_d = pc_q + 32'd4;
            end
            outst_d = outst_q + {1'b0, w_grant} - {1'b0, w_rsp_keep};
            if (w_rsp_drop) begin
                drop_d = drop_q - 3'd1;
            end
            case ({w_pop, w_rsp_keep})
                2'b10: begin
                    b0_inst_d = b1_inst_q;
                    b0_pc_d   = b1_pc_q;
                    occ_d     = occ_q - 2'd1;
                end
                2'b01: begin
                    if (occ_q == 2'd0) begin
                        b0_inst_d = i_ibus_rdata;
                        b0_pc_d   = w_rsp_pc;
                        occ_d     = 2'd1;
                    end else if (occ_q == 2'd1) begin
                        b1_inst_d = i_ibus_rdata;
                        b1_pc_d   = w_rsp_pc;
                        occ_d     = 2'd2;
                    end
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        b0_inst_d = i_ibus_rdata;
                        b0_pc_d   = w_rsp_pc;
                    end else begin
                        b0_inst_d = b1_inst_q;
                        b0_pc_d   = b1_pc_q;
                        b1_inst_d = i_ibus_rdata;
                        b1_pc_d   = w_rsp_pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q      <= RESET_PC;
            outst_q   <= 2'd0;
            drop_q    <= 3'd0;
            occ_q     <= 2'd0;
            b0_inst_q <= NOP_INST;
            b0_pc_q   <= 32'd0;
            b1_inst_q <= NOP_INST;
            b1_pc_q   <= 32'd0;
`ifdef IF_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            occ_q     <= occ_d;
            b0_inst_q <= b0_inst_d;
            b0_pc_q   <= b0_pc_d;
            b1_inst_q <= b1_inst_d;
            b1_pc_q   <= b1_pc_d;
`ifdef IF_MISALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

endmodule
`default_nettype wire
